// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives imem req/ack, applies redirects, squashes wrong-path fetches.
// Optional misaligned-PC detection is enabled by defining FETCH_ALIGN_CHK_EN.

module fetch_mux #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  output logic [W-1:0] y
);
  assign y = sel ? op2 : op1;
endmodule

module fetch_ctrl #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int             PC_INC   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stall,
  input  logic         halt,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic         inst_valid,
  output logic [N-1:0] inst_out,
  output logic [N-1:0] inst_pc,
  output logic         mux_sel,
  output logic         busy,
  output logic         misalign_fault
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_STALL  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [N-1:0] PC_STEP = N'(PC_INC);

  logic [1:0]   state_reg, state_next;
  logic [N-1:0] pc_reg, pc_next;
  logic         redir_pend_reg, redir_pend_next;
  logic [N-1:0] redir_target_reg, redir_target_next;
  logic         halt_pend_reg, halt_pend_next;
  logic         inst_valid_reg, inst_valid_next;
  logic [N-1:0] inst_out_reg, inst_out_next;
  logic [N-1:0] inst_pc_reg, inst_pc_next;

  logic         in_req;
  logic         acked;
  logic         squash;
  logic         pc_load;
  logic [N-1:0] redir_op;
  logic [N-1:0] mux_out;
  logic         misaligned_load;
  logic         fault_hold;

  assign in_req   = (state_reg == S_REQ);
  assign acked    = in_req && imem_ack;
  // A redirect coinciding with the ack is applied immediately, bypassing the latch.
  assign squash   = acked && (redir_pend_reg || branch_taken);
  assign redir_op = branch_taken ? branch_target : redir_target_reg;
  assign mux_sel  = in_req ? squash : branch_taken;
  assign pc_load  = acked || (!in_req && branch_taken);

  fetch_mux #(.W(N)) u_fetch_mux (
    .sel (mux_sel),
    .op1 (pc_reg + PC_STEP),
    .op2 (redir_op),
    .y   (mux_out)
  );

`ifdef FETCH_ALIGN_CHK_EN
  localparam logic [N-1:0] ALIGN_MASK = N'(PC_INC - 1);
  logic misalign_reg;

  assign misaligned_load = pc_load && ((mux_out & ALIGN_MASK) != '0);
  assign fault_hold      = misalign_reg;
  assign misalign_fault  = misalign_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_reg <= 1'b0;
    end else if (misaligned_load) begin
      misalign_reg <= 1'b1;
    end
  end
`else
  assign misaligned_load = 1'b0;
  assign fault_hold      = 1'b0;
  assign misalign_fault  = 1'b0;
`endif

  always_comb begin
    state_next        = state_reg;
    pc_next           = pc_reg;
    redir_pend_next   = redir_pend_reg;
    redir_target_next = redir_target_reg;
    halt_pend_next    = halt_pend_reg;
    inst_valid_next   = 1'b0;
    inst_out_next     = inst_out_reg;
    inst_pc_next      = inst_pc_reg;

    if (pc_load) pc_next = mux_out;

    case (state_reg)
      S_REQ: begin
        if (imem_ack) begin
          if (!squash) begin
            inst_valid_next = 1'b1;
            inst_out_next   = imem_rdata;
            inst_pc_next    = pc_reg;
          end
          redir_pend_next = 1'b0;
          if (halt_pend_reg || halt) state_next = S_HALTED;
          else if (stall)            state_next = S_STALL;
        end else begin
          if (branch_taken) begin
            redir_pend_next   = 1'b1;
            redir_target_next = branch_target;
          end
          if (halt) halt_pend_next = 1'b1;
        end
      end
      S_STALL: begin
        if (halt)        state_next = S_HALTED;
        else if (!stall) state_next = S_REQ;
      end
      default: begin
        // IDLE and HALTED; a latched alignment fault keeps the fetcher parked.
        if (start && !halt && !fault_hold) state_next = S_REQ;
      end
    endcase

    if (misaligned_load) state_next = S_HALTED;
    if (state_next == S_HALTED) halt_pend_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg        <= S_IDLE;
      pc_reg           <= RESET_PC;
      redir_pend_reg   <= 1'b0;
      redir_target_reg <= '0;
      halt_pend_reg    <= 1'b0;
      inst_valid_reg   <= 1'b0;
      inst_out_reg     <= '0;
      inst_pc_reg      <= '0;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      redir_pend_reg   <= redir_pend_next;
      redir_target_reg <= redir_target_next;
      halt_pend_reg    <= halt_pend_next;
      inst_valid_reg   <= inst_valid_next;
      inst_out_reg     <= inst_out_next;
      inst_pc_reg      <= inst_pc_next;
    end
  end

  assign imem_req   = in_req;
  assign imem_addr  = pc_reg;
  assign busy       = (state_reg == S_REQ) || (state_reg == S_STALL);
  assign inst_valid = inst_valid_reg;
  assign inst_out   = inst_out_reg;
  assign inst_pc    = inst_pc_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a driver issues stimulus and pushes expected deliveries, a monitor pops them.
// Honours FETCH_ALIGN_CHK_EN in its reference model.
module tb_fetch_ctrl;
  localparam logic [31:0] RPC = 32'hFFFF_FFFC;
`ifdef FETCH_ALIGN_CHK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, stall, halt, branch_taken, imem_ack;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, inst_valid, mux_sel, busy, misalign_fault;
  logic [31:0] imem_addr, inst_out, inst_pc;

  always #5 clk = ~clk;

  fetch_ctrl #(.N(32), .RESET_PC(RPC), .PC_INC(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_out(inst_out),
    .inst_pc(inst_pc), .mux_sel(mux_sel), .busy(busy),
    .misalign_fault(misalign_fault)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Reference model: is the fetcher running, is it parked by a stall, and what is pending.
  logic        m_run = 1'b0, m_stalled = 1'b0, m_redir = 1'b0, m_hreq = 1'b0, m_fault = 1'b0;
  logic [31:0] m_pc = '0, m_tgt = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(input logic r, input logic s, input logic st, input logic h,
                      input logic b, input logic [31:0] t, input logic a);
    logic        m_req, sq, loaded;
    logic [31:0] d;
    m_req  = m_run && !m_stalled;
    loaded = 1'b0;
    d = $urandom;
    rst = r; start = s; stall = st; halt = h;
    branch_taken = b; branch_target = t;
    imem_ack = a && m_req;
    imem_rdata = d;
    #1;
    if (r) begin
      chk("imem_req", 32'(imem_req), 32'(m_req));
      if (m_req) chk("imem_addr", imem_addr, m_pc);
      chk("busy", 32'(busy), 32'(m_run));
      chk("mux_sel", 32'(mux_sel), m_req ? 32'(imem_ack && (m_redir || b)) : 32'(b));
      chk("misalign_fault", 32'(misalign_fault), 32'(m_fault));
    end
    @(posedge clk);
    if (!r) begin
      m_run = 0; m_stalled = 0; m_redir = 0; m_hreq = 0; m_fault = 0; m_pc = RPC;
    end else if (m_req) begin
      if (imem_ack) begin
        sq = m_redir || b;
        if (!sq) exp_q.push_back('{pc: m_pc, inst: d});
        m_pc = sq ? (b ? t : m_tgt) : m_pc + 32'd4;
        loaded = 1'b1;
        m_redir = 0;
        if (m_hreq || h) begin m_run = 0; m_hreq = 0; end
        else if (st) m_stalled = 1;
      end else begin
        if (b) begin m_redir = 1; m_tgt = t; end
        if (h) m_hreq = 1;
      end
    end else if (m_run) begin
      if (b) begin m_pc = t; loaded = 1'b1; end
      if (h) m_run = 0;
      else if (!st) m_stalled = 0;
    end else begin
      if (b) begin m_pc = t; loaded = 1'b1; end
      if (s && !h && !m_fault) begin m_run = 1; m_stalled = 0; end
    end
    if (ALIGN_EN && loaded && m_pc[1:0] != 2'b00) begin
      m_fault = 1; m_run = 0; m_stalled = 0; m_hreq = 0;
    end
    @(negedge clk);
  endtask

  // Monitor: every delivered instruction must match the head of the expectation queue.
  always @(negedge clk) begin
    if (inst_valid === 1'b1 || exp_q.size() != 0) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_inst actual pc=%h inst=%h expected=none", inst_pc, inst_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("inst_valid", 32'(inst_valid), 32'd1);
        chk("inst_pc", inst_pc, e.pc);
        chk("inst_out", inst_out, e.inst);
        $display("deliver pc=%h inst=%h", e.pc, e.inst);
      end
    end
  end

  logic [31:0] seq_addr [4];

  initial begin
    logic [31:0] t;
    seq_addr[0] = 32'hFFFF_FFFC; seq_addr[1] = 32'h0; seq_addr[2] = 32'h4; seq_addr[3] = 32'h8;
    rst = 0; start = 0; stall = 0; halt = 0; branch_taken = 0; branch_target = 0;
    imem_ack = 0; imem_rdata = 0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_out", inst_out, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mux_sel", 32'(mux_sel), 32'd0);
    chk("rst_fault", 32'(misalign_fault), 32'd0);

    // Sequential fetch with wrap past the top of the address space.
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imem_addr, seq_addr[i]);
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1);
    end
    // Redirect while the request to 0xC is pending: 0xC squashed.
    step(1, 0, 0, 0, 1, 32'h100, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("redir_addr", imem_addr, 32'h100);
    // Stall on ack, then resume.
    step(1, 0, 1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("stall_req", 32'(imem_req), 32'd0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("resume_addr", imem_addr, 32'h104);
    // Halt mid-request, then restart.
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("halt_busy", 32'(busy), 32'd0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("restart_addr", imem_addr, 32'h108);
    // Misaligned redirect together with the ack.
    step(1, 0, 0, 0, 1, 32'h102, 1);
    chk("misalign_req", 32'(imem_req), 32'(!ALIGN_EN));
    chk("misalign_flag", 32'(misalign_fault), 32'(ALIGN_EN));
    chk("misalign_addr", imem_addr, 32'h102);
    // Reset during an outstanding request aborts it.
    step(0, 0, 0, 0, 0, 0, 1);
    chk("abort_req", 32'(imem_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("abort_restart_addr", imem_addr, RPC);

    for (int i = 0; i < 3000; i++) begin
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) t[1] = 1'b1;
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 9) == 0), t, ($urandom_range(0, 1) == 0));
    end

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage sequencer: owns the program counter and drives the select of an internal `fetch_mux` instance.
  - op1 = `pc + PC_INC`.
  - op2 = latched redirect target.
- Issues instruction-memory requests with a req/ack handshake, applies branch redirects, squashes wrong-path fetches, and honours stall/halt from later stages.
- Sits between the decode/branch unit and instruction memory.

Parameters:
- N, 32, PC / address and instruction width.
- RESET_PC, 0, PC value loaded at reset.
- PC_INC, 4, sequential PC increment.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  leave IDLE/HALTED and begin fetching from the current pc.
- stall  input  1  level; block issuing new requests.
- halt  input  1  level; stop fetching after the outstanding request.
- branch_taken  input  1  one-cycle redirect pulse.
- branch_target  input  N  redirect address, valid with branch_taken.
- imem_req  output  1  request to instruction memory.
- imem_addr  output  N  request address (= pc).
- imem_ack  input  1  memory accepted the request and imem_rdata is valid.
- imem_rdata  input  N  fetched instruction.
- inst_valid  output  1  inst_out/inst_pc valid for one cycle.
- inst_out  output  N  fetched instruction.
- inst_pc  output  N  address of inst_out.
- mux_sel  output  1  fetch_mux select; 0 = sequential (op1), 1 = redirect (op2).
- busy  output  1  high in REQ or STALL.
- misalign_fault  output  1  see Optional Feature.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State = IDLE, pc = RESET_PC.
  - imem_req = 0, inst_valid = 0, inst_out = 0, inst_pc = 0.
  - mux_sel = 0, busy = 0, misalign_fault = 0.
  - redir_pend = 0, halt_pend = 0.
  - Reset overrides every other input and aborts any outstanding request; an ack arriving during reset is ignored.
- States: IDLE, REQ, STALL, HALTED.
- IDLE / HALTED:
  - imem_req = 0.
  - start=1 → REQ next cycle.
  - start is ignored while halt=1.
- REQ:
  - imem_req = 1; imem_addr = pc, held stable until imem_ack.
  - req is never dropped before ack, regardless of stall, halt or branch_taken.
  - On ack (one-cycle latency):
    - If no squash: inst_out = imem_rdata, inst_pc = pc, inst_valid = 1 for exactly one cycle.
    - Next pc = `fetch_mux` output.
    - Next state priority: halt_pend or halt → HALTED; else stall → STALL; else stay REQ (back-to-back, new address next cycle).
- STALL:
  - imem_req = 0.
  - Go to REQ in the cycle after stall is seen low, unless halt → HALTED.
- Redirect:
  - branch_taken in REQ without ack → latch target, set redir_pend.
  - branch_taken together with ack → same, applied immediately.
  - At the ack: the in-flight instruction is squashed (inst_valid stays 0), mux_sel = 1 that cycle, pc ← target, redir_pend cleared.
  - branch_taken in IDLE/STALL/HALTED → pc ← branch_target next cycle, mux_sel = 1 for that cycle, no squash needed.
  - A second branch_taken before the ack overwrites the latched target (last one wins).
- mux_sel:
  - Combinational; 1 only in a cycle where pc loads the redirect target, otherwise 0.
- Halt:
  - halt seen in REQ → set halt_pend; the outstanding instruction is still delivered (unless squashed).
  - halt_pend cleared on entering HALTED.
  - A redirect coinciding with halt still updates pc before HALTED.
- Arithmetic:
  - pc + PC_INC wraps modulo 2^N; 0xFFFF_FFFC + 4 = 0x0000_0000, with no flag.
- busy = (state == REQ || state == STALL).

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined:
  - Any pc load whose low log2(PC_INC) bits are nonzero sets misalign_fault = 1 (sticky until reset).
  - Also forces HALTED next cycle; no imem_req is issued to the misaligned address.
- Undefined:
  - misalign_fault tied 0; misaligned targets are fetched as-is.

Test Plan:
- Reset then start, with imem_ack one cycle after each req → imem_addr 0x0, 0x4, 0x8 on consecutive requests; inst_valid pulses with inst_pc matching; mux_sel stays 0.
- branch_taken with target 0x100 while a req to 0x8 is pending, ack two cycles later → no inst_valid for 0x8; mux_sel = 1 at the ack; next imem_addr = 0x100.
- stall=1 asserted during REQ, ack arrives → the instruction is delivered, state goes to STALL with imem_req = 0; stall=0 → req resumes at pc+4 one cycle later.
- halt=1 mid-request → the current instruction is delivered, then HALTED with busy = 0; after halt=0 and start=1, fetch resumes at the following pc.
- RESET_PC = 0xFFFF_FFFC → the second request goes to 0x0000_0000; rst=0 asserted mid-request → the next cycle has imem_req = 0 and pc = RESET_PC.
- With FETCH_ALIGN_CHK_EN defined, branch to 0x102 → misalign_fault = 1, state HALTED, no request to 0x102.
- Without FETCH_ALIGN_CHK_EN, the same branch to 0x102 → req to 0x102 issued and misalign_fault = 0.
